ultrasonic_sensor_uart_receiver: RTL

//  UART receive path (8N1, LSB first) for the ultrasonic sensor board; opposite direction of the 9600-baud distance transmitter.

---
 rtl/ultrasonic_sensor_pkg.sv | 33 +++
 rtl/ultrasonic_sensor_cmd_decoder.sv | 35 +++
 rtl/ultrasonic_sensor_uart_receiver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ultrasonic_sensor_pkg.sv
// ---------------------------------------------------------------------------
// ultrasonic_sensor_pkg : shared UART-rx states, ASCII commands, bit timing
// Rev 1.0 ; optional 8E1 framing via UART_RX_PARITY_EN
// ---------------------------------------------------------------------------
`default_nettype none

package ultrasonic_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_t;

  localparam logic [7:0] CMD_START_UC = 8'h53;  // 'S'
  localparam logic [7:0] CMD_START_LC = 8'h73;  // 's'
  localparam logic [7:0] CMD_PAUSE_UC = 8'h50;  // 'P'
  localparam logic [7:0] CMD_PAUSE_LC = 8'h70;  // 'p'
  localparam logic [7:0] CMD_CM_UC    = 8'h43;  // 'C'
  localparam logic [7:0] CMD_CM_LC    = 8'h63;  // 'c'
  localparam logic [7:0] CMD_INCH_UC  = 8'h49;  // 'I'
  localparam logic [7:0] CMD_INCH_LC  = 8'h69;  // 'i'

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ultrasonic_sensor_cmd_decoder.sv
// ---------------------------------------------------------------------------
// ultrasonic_sensor_cmd_decoder : received byte -> measure-enable / unit levels
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ultrasonic_sensor_cmd_decoder
  import ultrasonic_sensor_pkg::*;
(
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic [7:0] Data_i,
  input  logic       Data_valid_i,
  output logic       Measure_en_o,
  output logic       Cm_or_inches_o
);

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      Measure_en_o   <= 1'b0;
      Cm_or_inches_o <= 1'b0;
    end else if (Data_valid_i) begin
      case (Data_i)
        CMD_START_UC, CMD_START_LC: Measure_en_o   <= 1'b1;
        CMD_PAUSE_UC, CMD_PAUSE_LC: Measure_en_o   <= 1'b0;
        CMD_CM_UC,    CMD_CM_LC:    Cm_or_inches_o <= 1'b0;
        CMD_INCH_UC,  CMD_INCH_LC:  Cm_or_inches_o <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ultrasonic_sensor_uart_receiver.sv
// ---------------------------------------------------------------------------
// ultrasonic_sensor_uart_receiver : 8N1 UART rx + ASCII command decode
// Rev 1.0 ; define UART_RX_PARITY_EN for 8E1 framing with even-parity check
// ---------------------------------------------------------------------------
`default_nettype none

module ultrasonic_sensor_uart_receiver
  import ultrasonic_sensor_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic       Rx_i,
  output logic [7:0] Data_o,
  output logic       Data_valid_o,
  output logic       Frame_error_o,
  output logic       Measure_en_o,
  output logic       Cm_or_inches_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  rx_state_t              state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bad;
`endif

  // Sync chain resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge Clk_i) begin
    if (!Reset_i) sync <= '1;
    else          sync <= {sync[SYNC_STAGES-2:0], Rx_i};
  end

  assign rx_s = sync[SYNC_STAGES-1];

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      Data_o        <= '0;
      Data_valid_o  <= 1'b0;
      Frame_error_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad    <= 1'b0;
`endif
    end else begin
      Data_valid_o  <= 1'b0;
      Frame_error_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == 3'd7) state <= ST_PARITY;
`else
            if (bit_cnt == 3'd7) state <= ST_STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            parity_bad <= ^{shift, rx_s};
            state      <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              Frame_error_o <= 1'b1;
              state         <= ST_BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad) begin
              Frame_error_o <= 1'b1;
              state         <= ST_IDLE;
`endif
            end else begin
              Data_o       <= shift;
              Data_valid_o <= 1'b1;
              state        <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // A held-low line must return high before another start is accepted.
        ST_BREAK: if (rx_s) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  ultrasonic_sensor_cmd_decoder u_cmd_decoder (
    .Clk_i          (Clk_i),
    .Reset_i        (Reset_i),
    .Data_i         (Data_o),
    .Data_valid_i   (Data_valid_o),
    .Measure_en_o   (Measure_en_o),
    .Cm_or_inches_o (Cm_or_inches_o)
  );

endmodule

`default_nettype wire
